// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_sequencer
//  Description : Collects three bytes (A, B, OP) from a receive buffer,
//                presents them to an external combinational ALU, captures
//                the result and writes it to a transmit buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_sequencer #(
    parameter int DBIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rx_rd,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [DBIT-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [DBIT-1:0] tx_data,
    output logic            busy,
    output logic [7:0]      op_count
);

    localparam logic [1:0] S_GET  = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [1:0] IDX_A  = 2'd0;
    localparam logic [1:0] IDX_B  = 2'd1;
    localparam logic [1:0] IDX_OP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DBIT-1:0] a_q, a_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] op_q, op_d;
    logic [DBIT-1:0] txd_q, txd_d;
    logic [7:0]      cnt_q, cnt_d;

    // State register: all sequential state, synchronous reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GET;
            idx_q   <= IDX_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            txd_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: byte collection, result capture and send handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_GET: begin
                if (!rx_empty) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                // rx_data is valid the cycle after the read pulse
                case (idx_q)
                    IDX_A:   a_d  = rx_data;
                    IDX_B:   b_d  = rx_data;
                    default: op_d = rx_data;
                endcase
                if (idx_q == IDX_A || idx_q == IDX_B) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_GET;
                end else begin
                    idx_d   = IDX_A;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands are stable here, so the ALU output is settled
                txd_d   = alu_result;
                state_d = S_SEND;
            end
            default: begin
                if (!tx_full) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_GET;
                end
            end
        endcase
    end

    // Output logic: strobes follow the buffer flags and are masked by reset
    always_comb begin
        rx_rd = (state_q == S_GET)  && !rx_empty && !reset;
        tx_wr = (state_q == S_SEND) && !tx_full  && !reset;
        busy  = !((state_q == S_GET) && (idx_q == IDX_A));
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign tx_data  = txd_q;
    assign op_count = cnt_q;

endmodule
`default_nettype wire
